argon_stack: RTL
================

# argon_stack

Parametrised hardware stack unit for the Argon CPU. It sits on the unit bus as unit `ID_STACK` and accepts PUSH/POP/PEEK/CLEAR commands through a valid/ready request channel. Every accepted command produces exactly one response beat carrying data and an error code. This block generalises the fixed-width stack slot into a configurable width and depth with distinct error reporting.

## Interface
- `WIDTH`, default 16 (`WORDSIZE`): data word width.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `UNIT_ID`, default 4'h4 (`ID_STACK`): bus ID this instance answers to.
- `COMMAND_WIDTH`, default 4: command field width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `bus_valid` in 1: request present.
- `bus_ready` out 1: unit can accept a request this cycle.
- `bus_id` in 4: target unit ID.
- `bus_command` in COMMAND_WIDTH: command opcode.
- `bus_data` in WIDTH: PUSH operand.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_data` out WIDTH: POP/PEEK result or watermark; 0 otherwise.
- `resp_error` out 4: `error_t` code.
- `count` out $clog2(DEPTH+1): current occupancy.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `watermark` out $clog2(DEPTH+1): maximum occupancy since reset or CLEAR.

## Operation
- Accept condition: `bus_valid && bus_ready && bus_id == UNIT_ID`.
- Requests with a mismatched ID are ignored: no state change, no response.
- FSM states:
  - IDLE: `bus_ready`=1.
  - READ: memory read in flight.
  - RESP: `resp_valid`=1 for one cycle, then return to IDLE.
- FSM transitions:
  - IDLE→READ on an accepted POP or PEEK when not empty.
  - IDLE→RESP on any other accepted command.
  - READ→RESP always.
- `bus_ready`=0 in READ and RESP. There is no response back-pressure.
- Commands:
  - 0 NOP: returns ERR_NONE.
  - 1 PUSH: write `bus_data` at the stack pointer; count+1.
  - 2 POP: return the top entry; count−1.
  - 3 PEEK: return the top entry; no count change.
  - 4 CLEAR: count←0, watermark←0, ERR_NONE.
  - 5 READ_WATERMARK: see Configuration.
  - Others: ERR_INVALID_COMMAND, no state change.
- Boundary behaviour:
  - PUSH when full: no write, count unchanged, ERR_OVERFLOW.
  - POP/PEEK when empty: no read, count unchanged, ERR_UNDERFLOW, `resp_data`=0.
- Count/pointer update occurs at the accept edge. `full`, `empty` and `count` reflect the new value from the next cycle.
- Memory contents are not reset. Reads of stale entries only occur through a legal POP/PEEK.
- Reset mid-operation: FSM→IDLE; count, watermark and all outputs→0 immediately; any pending response is dropped.

## Timing
- Reset values: `bus_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_error`=ERR_NONE, `count`=0, `full`=0, `empty`=1, `watermark`=0.
- Latency from the accept edge to `resp_valid`:
  - 1 cycle for NOP, PUSH, CLEAR, READ_WATERMARK, errors.
  - 2 cycles for a successful POP/PEEK.
- `resp_data` and `resp_error` are valid only while `resp_valid`=1 and are driven to 0 otherwise.
- Maximum throughput: one command every 2 cycles (non-read) or every 3 cycles (read).

## Configuration
- Macro: `ARGON_STACK_WATERMARK_EN`.
- Defined:
  - Watermark register is updated to max(watermark, new count) after each PUSH.
  - Command 5 returns the watermark, zero-extended, with ERR_NONE.
- Undefined:
  - `watermark` is tied to 0.
  - Command 5 returns ERR_INVALID_COMMAND.
  - No watermark register is synthesised.

## Structure
- `constants_pkg` holds:
  - `stack_cmd_t` enum (NOP, PUSH, POP, PEEK, CLEAR, READ_WATERMARK).
  - `error_t` (4-bit).
  - ERR_NONE=0, ERR_OVERFLOW=1, ERR_UNDERFLOW=2, ERR_INVALID_COMMAND=3.
  - `ID_STACK`.
- Sub-module `argon_stack_mem`: DEPTH×WIDTH RAM with one write port and one synchronous read port.
- The FSM, pointer and watermark logic live in `argon_stack`.

## Test plan
- Reset, then PUSH 16'hA5A5 with ID 4'h4 → resp one cycle later, ERR_NONE; count=1, empty=0.
- PUSH 1..16 (DEPTH=16), then PUSH 99 → full=1, ERR_OVERFLOW, count stays 16; POP → 16 after 2 cycles.
- POP on empty → ERR_UNDERFLOW, `resp_data`=0, count=0; PEEK after PUSH 7 → 7, count unchanged at 1.
- Request with `bus_id`=4'h1, PUSH 5 → no `resp_valid`, count unchanged; command 4'hE → ERR_INVALID_COMMAND.
- With the macro defined: PUSH×5, POP×3, command 5 → `resp_data`=5; CLEAR → watermark=0. Without the macro: command 5 → ERR_INVALID_COMMAND.
- Assert `reset_n` low during READ of a POP → no `resp_valid`; count=0 and `bus_ready`=1 immediately.

Source files
------------

// File: rtl/constants_pkg.sv
// constants_pkg: shared Argon unit-bus constants for the stack unit.
//   WORDSIZE    - default stack word width
//   ID_STACK    - unit-bus ID of the stack unit
//   stack_cmd_t - stack command opcodes
//   error_t     - 4-bit response error codes
package constants_pkg;

    localparam int WORDSIZE = 16;
    localparam logic [3:0] ID_STACK = 4'h4;

    typedef enum logic [3:0] {
        CMD_NOP            = 4'd0,
        CMD_PUSH           = 4'd1,
        CMD_POP            = 4'd2,
        CMD_PEEK           = 4'd3,
        CMD_CLEAR          = 4'd4,
        CMD_READ_WATERMARK = 4'd5
    } stack_cmd_t;

    typedef enum logic [3:0] {
        ERR_NONE            = 4'd0,
        ERR_OVERFLOW        = 4'd1,
        ERR_UNDERFLOW       = 4'd2,
        ERR_INVALID_COMMAND = 4'd3
    } error_t;

endpackage

// File: rtl/argon_stack_mem.sv
// argon_stack_mem: DEPTH x WIDTH stack storage, one write port, one synchronous read port.
//   clk   in  - clock
//   we    in  - write enable
//   waddr in  - write address
//   wdata in  - write data
//   re    in  - read enable; rdata updates on the next edge and holds until the next read
//   raddr in  - read address
//   rdata out - registered read data
module argon_stack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/argon_stack.sv
// argon_stack: parametrised stack unit on the Argon unit bus (PUSH/POP/PEEK/CLEAR).
//   clk, reset_n            - clock, asynchronous active-low reset
//   bus_valid/bus_ready     - request handshake
//   bus_id                  - target unit ID, must match UNIT_ID
//   bus_command, bus_data   - opcode and PUSH operand
//   resp_valid              - one-cycle response strobe
//   resp_data, resp_error   - response payload, zero outside resp_valid
//   count, full, empty      - occupancy status
//   watermark               - peak occupancy since reset or CLEAR
// Optional feature: define ARGON_STACK_WATERMARK_EN to build the watermark
// register and enable command 5 (READ_WATERMARK).
module argon_stack
    import constants_pkg::*;
#(
    parameter int         WIDTH         = WORDSIZE,
    parameter int         DEPTH         = 16,
    parameter logic [3:0] UNIT_ID       = ID_STACK,
    parameter int         COMMAND_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       bus_valid,
    output logic                       bus_ready,
    input  logic [3:0]                 bus_id,
    input  logic [COMMAND_WIDTH-1:0]   bus_command,
    input  logic [WIDTH-1:0]           bus_data,
    output logic                       resp_valid,
    output logic [WIDTH-1:0]           resp_data,
    output logic [3:0]                 resp_error,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] watermark
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    error_t           err_q, err_nxt;
    logic             from_mem, from_mem_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             acc, we, re;
    logic [WIDTH-1:0] rdata;

    assign bus_ready  = state == IDLE;
    assign acc        = bus_valid && bus_ready && bus_id == UNIT_ID;
    assign count      = cnt;
    assign full       = cnt == CW'(DEPTH);
    assign empty      = cnt == '0;
    assign resp_valid = state == RESP;
    assign resp_data  = resp_valid ? (from_mem ? rdata : data_q) : '0;
    assign resp_error = resp_valid ? err_q : ERR_NONE;

    // The read is launched at the accept edge so the top entry sits in rdata
    // during READ and is still held there in RESP.
    argon_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (cnt[AW-1:0]),
        .wdata (bus_data),
        .re    (re),
        .raddr (AW'(cnt - 1'b1)),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        err_nxt      = err_q;
        from_mem_nxt = from_mem;
        data_nxt     = data_q;
        we           = 1'b0;
        re           = 1'b0;
        case (state)
            IDLE: if (acc) begin
                state_nxt    = RESP;
                err_nxt      = ERR_NONE;
                from_mem_nxt = 1'b0;
                data_nxt     = '0;
                case (bus_command)
                    COMMAND_WIDTH'(CMD_NOP): ;
                    COMMAND_WIDTH'(CMD_PUSH):
                        if (full) err_nxt = ERR_OVERFLOW;
                        else begin
                            we      = 1'b1;
                            cnt_nxt = cnt + 1'b1;
                        end
                    COMMAND_WIDTH'(CMD_POP), COMMAND_WIDTH'(CMD_PEEK):
                        if (empty) err_nxt = ERR_UNDERFLOW;
                        else begin
                            re           = 1'b1;
                            state_nxt    = READ;
                            from_mem_nxt = 1'b1;
                            if (bus_command == COMMAND_WIDTH'(CMD_POP)) cnt_nxt = cnt - 1'b1;
                        end
                    COMMAND_WIDTH'(CMD_CLEAR): cnt_nxt = '0;
`ifdef ARGON_STACK_WATERMARK_EN
                    COMMAND_WIDTH'(CMD_READ_WATERMARK): data_nxt = WIDTH'(watermark);
`endif
                    default: err_nxt = ERR_INVALID_COMMAND;
                endcase
            end
            READ:    state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            err_q    <= ERR_NONE;
            from_mem <= 1'b0;
            data_q   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            err_q    <= err_nxt;
            from_mem <= from_mem_nxt;
            data_q   <= data_nxt;
        end
    end

`ifdef ARGON_STACK_WATERMARK_EN
    logic [CW-1:0] wm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wm <= '0;
        else if (acc && bus_command == COMMAND_WIDTH'(CMD_CLEAR)) wm <= '0;
        else if (we && cnt_nxt > wm) wm <= cnt_nxt;
    end

    assign watermark = wm;
`else
    assign watermark = '0;
`endif

endmodule
